// File: rtl/reg_bank.sv
// Register file with a registered operand-fetch stage feeding the diff unit.
// Reads bypass same-cycle write-back; the held pair is frozen while stalled.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] inreg1,
  output logic [DATA_W-1:0] inreg2
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_inreg1;
  logic [DATA_W-1:0] r_inreg2;

  logic              w_accept;
  logic              w_wr_hit;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_wr_hit  = wr_en && (wr_addr != 5'd0) && (int'(wr_addr) < NREG);
  assign out_valid = r_out_valid;
  assign inreg1    = r_inreg1;
  assign inreg2    = r_inreg2;

  // Index 0 and out-of-range indices read as zero; a live write to the
  // same index wins over the stored value.
  always_comb begin
    w_rs_val = '0;
    if (rs != 5'd0 && int'(rs) < NREG) begin
      if (wr_en && wr_addr == rs) w_rs_val = wr_data;
      else                        w_rs_val = r_regs[rs[AW-1:0]];
    end
  end

  always_comb begin
    w_rt_val = '0;
    if (rt != 5'd0 && int'(rt) < NREG) begin
      if (wr_en && wr_addr == rt) w_rt_val = wr_data;
      else                        w_rt_val = r_regs[rt[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_hit) begin
      r_regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Operands are captured only on acceptance, so later writes never
  // disturb a pair waiting on the diff unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_inreg1    <= '0;
      r_inreg2    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_inreg1    <= w_rs_val;
      r_inreg2    <= w_rt_val;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed plus random checks of reg_bank against an array-based model of
// the register file and the single-entry operand hold.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inreg1;
  logic [31:0] inreg2;

  reg_bank #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .rs(rs), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready), .inreg1(inreg1), .inreg2(inreg2)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  // Reference model
  logic [31:0] mreg [32];
  logic        mv;
  logic [31:0] e1, e2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    assert (act === exp) npass++;
    else $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)", tag, act, act, exp, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mv = 1'b0; e1 = '0; e2 = '0;
  endtask

  function automatic logic [31:0] mval(input logic [4:0] x, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (x == 0) return '0;
    if (we && wa == x) return wd;
    return mreg[x];
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mv});
    chk({tag, ".inreg1"}, inreg1, e1);
    chk({tag, ".inreg2"}, inreg2, e2);
  endtask

  // One clock: drive, check in_ready, advance the model, check the edge result.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic iv, input logic [4:0] a,
                       input logic [4:0] b, input logic ordy);
    logic er;
    wr_en = we; wr_addr = wa; wr_data = wd;
    in_valid = iv; rs = a; rt = b; out_ready = ordy;
    #1;
    er = !mv || ordy;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, er});
    if (iv && er) begin
      e1 = mval(a, we, wa, wd);
      e2 = mval(b, we, wa, wd);
      mv = 1'b1;
    end else if (ordy) begin
      mv = 1'b0;
    end
    if (we && wa != 0) mreg[wa] = wd;
    @(posedge clk); #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    in_valid = 0; rs = 0; rt = 0; out_ready = 0;
    model_clear();
    #12;
    check_out("rst_init");
    chk("rst_init.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // write then fetch
    cycle("wr_r3", 1, 5'd3, 32'd12, 0, 0, 0, 1);
    cycle("wr_r4", 1, 5'd4, 32'd34, 0, 0, 0, 1);
    cycle("fetch34", 0, 0, 0, 1, 5'd3, 5'd4, 1);
    cycle("bypass", 1, 5'd7, 32'd78, 1, 5'd7, 5'd4, 1);
    cycle("r0", 1, 5'd0, 32'd45, 1, 5'd0, 5'd0, 1);
    cycle("rs_eq_rt", 1, 5'd8, 32'd55, 1, 5'd8, 5'd8, 1);

    // stall: hold (16,68), new request blocked, then accepted
    cycle("wr_r5", 1, 5'd5, 32'd16, 0, 0, 0, 1);
    cycle("wr_r9", 1, 5'd9, 32'd68, 0, 0, 0, 1);
    cycle("stall_load", 0, 0, 0, 1, 5'd5, 5'd9, 0);
    cycle("stall_hold", 1, 5'd3, 32'd98, 1, 5'd3, 5'd4, 0);
    cycle("stall_hold2", 0, 0, 0, 1, 5'd3, 5'd4, 0);
    cycle("stall_release", 0, 0, 0, 1, 5'd3, 5'd4, 1);

    // back-to-back throughput
    for (int i = 0; i < 4; i++)
      cycle("tput", 0, 0, 0, 1, 5'(i + 3), 5'(9 - i), 1);
    cycle("drain", 0, 0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 2) != 0));

    // reset mid-stall
    cycle("pre_rst_wr5", 1, 5'd5, 32'd111, 0, 0, 0, 1);
    cycle("pre_rst_wr9", 1, 5'd9, 32'd222, 0, 0, 0, 1);
    cycle("pre_rst_stall", 0, 0, 0, 1, 5'd5, 5'd9, 0);
    rst = 1'b1;
    #1;
    model_clear();
    check_out("rst_async");
    chk("rst_async.in_ready", {31'd0, in_ready}, 32'd1);
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEAD; in_valid = 1; rs = 5'd5; rt = 5'd9;
    @(posedge clk); #1;
    check_out("rst_held");
    rst = 1'b0;
    cycle("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);
    cycle("post_rst_fetch", 0, 0, 0, 1, 5'd5, 5'd9, 1);
    cycle("post_rst_drain", 0, 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the register and operand width.
REQ-002 SHALL have parameter NREG, default 32, the number of registers; index width is 5 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, write-back strobe.
REQ-006 SHALL have port wr_addr, input, 5, write-back register index.
REQ-007 SHALL have port wr_data, input, DATA_W, write-back value.
REQ-008 SHALL have port in_valid, input, 1, operand-fetch request valid.
REQ-009 SHALL have port in_ready, output, 1, fetch request accepted this cycle.
REQ-010 SHALL have port rs, input, 5, first source register index.
REQ-011 SHALL have port rt, input, 5, second source register index.
REQ-012 SHALL have port out_valid, output, 1, operand pair valid for the diff unit.
REQ-013 SHALL have port out_ready, input, 1, diff unit consumes the operand pair.
REQ-014 SHALL have port inreg1, output, DATA_W, registered first operand, driving the diff unit's inreg1.
REQ-015 SHALL have port inreg2, output, DATA_W, registered second operand, driving the diff unit's inreg2.

Function
REQ-016 SHALL hold NREG registers of DATA_W bits; register 0 always reads 0.
REQ-017 SHALL write wr_data into regs[wr_addr] on a rising clk when wr_en=1 and wr_addr!=0; writes to index 0 are discarded.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-019 SHALL accept a request when in_valid && in_ready; on that edge inreg1 <= value(rs), inreg2 <= value(rt), and out_valid <= 1.
REQ-020 SHALL form value(x) as 0 if x=0; else wr_data if wr_en=1 and wr_addr=x in the same cycle (write bypass); else regs[x].
REQ-021 SHALL apply bypass independently to rs and rt; rs=rt yields identical operands.
REQ-022 SHALL clear out_valid on an edge with out_valid && out_ready && !(in_valid && in_ready).
REQ-023 SHALL keep inreg1, inreg2 and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL NOT refresh a held operand pair from later writes; the pair reflects register state at acceptance.
REQ-025 SHALL sustain one accepted fetch per cycle when out_ready is held at 1 (back-to-back, latency 1 cycle from acceptance to out_valid).
REQ-026 SHALL perform the write-back and a fetch in the same cycle independently of each other.

Reset
REQ-027 SHALL, while rst=1, clear all registers to 0, force out_valid=0 and inreg1=inreg2=0, independent of clk.
REQ-028 SHALL ignore wr_en and in_valid while rst=1; in_ready reads 1 during reset.
REQ-029 SHALL discard a held operand pair when reset is asserted mid-stall; no transfer occurs after deassertion until a new request.
REQ-030 SHALL resume normal operation on the first rising clk after rst deasserts.

Verification
REQ-031 Bench SHALL check reset: rst=1 mid-run -> out_valid=0, inreg1=inreg2=0; then fetch rs=5, rt=9 -> 0, 0.
REQ-032 Bench SHALL check write-then-fetch: write r3=12, r4=34; fetch rs=3, rt=4 next cycle -> inreg1=12, inreg2=34, out_valid=1 one cycle later.
REQ-033 Bench SHALL check bypass: same cycle write r7=78 and fetch rs=7, rt=4 -> inreg1=78, inreg2=34.
REQ-034 Bench SHALL check register 0: write r0=45, fetch rs=0, rt=0 -> both 0.
REQ-035 Bench SHALL check stall: out_ready=0 with pair (16,68) held; write r3=98 and present new request -> in_ready=0, outputs stay 16,68; raise out_ready -> new pair accepted next edge.
REQ-036 Bench SHALL check throughput: out_ready=1 and in_valid=1 for 4 cycles with distinct rs -> 4 consecutive valid pairs, no bubbles.
